// File: rtl/mem_port_arbiter_if.sv
// Avalon-MM host/agent bundle. The arbiter takes two slave-side views (fetch host, data host)
// and one master-side view toward the memory agent.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output read, write, address, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-MM memory agent between the instruction-fetch host (read-only) and the
// data host (read/write). One outstanding transfer; data wins ties unless fetch is starved.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  i_bus,
  mem_port_arbiter_if.slave  d_bus,
  mem_port_arbiter_if.master m_bus
);
  localparam int               CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, WAIT_I, WAIT_D} state_t;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
  } req_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  req_t             i_req, d_req, m_req;
  logic             d_any, fetch_wins;
  logic             i_wait, d_wait, i_rdv, d_rdv;
  logic [31:0]      i_rdata, d_rdata;
  logic             unused_fetch_wr;

  // The fetch host has no write path; its write strobe and payload are ignored.
  assign unused_fetch_wr = ^{i_bus.write, i_bus.writedata};

  assign d_any      = d_bus.read | d_bus.write;
  assign fetch_wins = i_bus.read && (!d_any || (starve_cnt >= LIMIT));

  always_comb begin
    i_req            = '0;
    i_req.read       = i_bus.read;
    i_req.address    = i_bus.address;
    i_req.byteenable = i_bus.byteenable;

    // A simultaneous read+write from the data host is a write; the read strobe is dropped.
    d_req            = '0;
    d_req.read       = d_bus.read & ~d_bus.write;
    d_req.write      = d_bus.write;
    d_req.address    = d_bus.address;
    d_req.byteenable = d_bus.byteenable;
    d_req.writedata  = d_bus.writedata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_bus.read || fetch_wins)
            starve_cnt <= '0;
          else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
          if (i_bus.read || d_any)
            state <= fetch_wins ? GRANT_I : GRANT_D;
        end
        GRANT_I: begin
          if (!i_bus.read)
            state <= IDLE;
          else if (!m_bus.waitrequest)
            state <= WAIT_I;
        end
        GRANT_D: begin
          if (!d_any)
            state <= IDLE;
          else if (!m_bus.waitrequest)
            state <= d_bus.write ? IDLE : WAIT_D;
        end
        WAIT_I, WAIT_D: begin
          if (m_bus.readdatavalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state; only the granted owner sees the memory stall or response.
  always_comb begin
    m_req   = '0;
    i_wait  = 1'b1;
    d_wait  = 1'b1;
    i_rdv   = 1'b0;
    d_rdv   = 1'b0;
    i_rdata = '0;
    d_rdata = '0;
    case (state)
      GRANT_I: begin
        m_req  = i_req;
        i_wait = m_bus.waitrequest;
      end
      GRANT_D: begin
        m_req  = d_req;
        d_wait = m_bus.waitrequest;
      end
      WAIT_I: begin
        i_rdv   = m_bus.readdatavalid;
        i_rdata = m_bus.readdatavalid ? m_bus.readdata : '0;
      end
      WAIT_D: begin
        d_rdv   = m_bus.readdatavalid;
        d_rdata = m_bus.readdatavalid ? m_bus.readdata : '0;
      end
      default: ;
    endcase
  end

  assign m_bus.read       = m_req.read;
  assign m_bus.write      = m_req.write;
  assign m_bus.address    = m_req.address;
  assign m_bus.byteenable = m_req.byteenable;
  assign m_bus.writedata  = m_req.writedata;

  assign i_bus.waitrequest   = i_wait;
  assign i_bus.readdata      = i_rdata;
  assign i_bus.readdatavalid = i_rdv;
  assign d_bus.waitrequest   = d_wait;
  assign d_bus.readdata      = d_rdata;
  assign d_bus.readdatavalid = d_rdv;
endmodule
